// File: rtl/nts_engine_scheduler_pkg.sv
// Shared definitions for the NTS engine scheduler: FSM state encoding and counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nts_engine_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  localparam int PKT_CNT_W = 32;  // completed-packet counter, wraps
  localparam int TMO_CNT_W = 16;  // timeout/abort counter, wraps
  localparam int TIMER_W   = 16;  // grant-to-busy watchdog, covers TIMEOUT up to 65535

endpackage

// File: rtl/nts_rr_picker.sv
// Round-robin first-free search: returns the first set bit of free at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; found=0 when no engine is free.
// Ports: free (per-engine free mask), ptr (search start), found (any free), idx (chosen engine).
module nts_rr_picker
  import nts_engine_scheduler_pkg::*;
#(
  parameter int NUM_ENGINES  = 4,
  parameter int ENGINE_IDX_W = 2
) (
  input  logic [NUM_ENGINES-1:0]  free,
  input  logic [ENGINE_IDX_W-1:0] ptr,
  output logic                    found,
  output logic [ENGINE_IDX_W-1:0] idx
);

  localparam logic [ENGINE_IDX_W:0] NUM_V = (ENGINE_IDX_W+1)'(NUM_ENGINES);

  logic [ENGINE_IDX_W:0]   sum;
  logic [ENGINE_IDX_W-1:0] cand;

  // Scan offsets from the far end down so the nearest free engine is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (ENGINE_IDX_W+1)'(i);
      if (sum >= NUM_V) begin
        sum = sum - NUM_V;
      end
      cand = sum[ENGINE_IDX_W-1:0];
      if (free[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/nts_engine_scheduler.sv
// Shares one dispatcher RX FIFO between NUM_ENGINES engines, granting round-robin to a free engine.
// Latency: grant visible 1 cycle after a packet is offered; data/valid broadcast and rd_en routing are combinational.
// Backpressure: holds in IDLE while all engines are busy; packet released by a one-cycle discard pulse.
// Ports: i_dispatch_* from dispatcher, o_dispatch_* back to it; i_engine_*/o_engine_* per-engine
//        handshake (one-hot to the granted engine); o_grant_idx, o_packets_dispatched, o_timeouts status.
module nts_engine_scheduler
  import nts_engine_scheduler_pkg::*;
#(
  parameter int NUM_ENGINES  = 4,
  parameter int ENGINE_IDX_W = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                    i_clk,
  input  logic                    i_areset_n,
  input  logic                    i_dispatch_packet_available,
  input  logic                    i_dispatch_fifo_empty,
  input  logic [7:0]              i_dispatch_data_valid,
  input  logic [63:0]             i_dispatch_fifo_rd_data,
  output logic                    o_dispatch_fifo_rd_en,
  output logic                    o_dispatch_packet_read_discard,
  input  logic [NUM_ENGINES-1:0]  i_engine_busy,
  input  logic [NUM_ENGINES-1:0]  i_engine_fifo_rd_en,
  output logic [NUM_ENGINES-1:0]  o_engine_packet_available,
  output logic [NUM_ENGINES-1:0]  o_engine_fifo_empty,
  output logic [7:0]              o_engine_data_valid,
  output logic [63:0]             o_engine_fifo_rd_data,
  output logic [ENGINE_IDX_W-1:0] o_grant_idx,
  output logic [PKT_CNT_W-1:0]    o_packets_dispatched,
  output logic [TMO_CNT_W-1:0]    o_timeouts
);

  localparam logic [TIMER_W-1:0]      TIMEOUT_V = TIMER_W'(TIMEOUT);
  localparam logic [ENGINE_IDX_W-1:0] LAST_IDX  = ENGINE_IDX_W'(NUM_ENGINES - 1);

  state_t                  state, state_next;
  logic [ENGINE_IDX_W-1:0] grant, rr_ptr, pick_idx, grant_inc;
  logic [NUM_ENGINES-1:0]  free_mask;
  logic                    pick_found;
  logic [TIMER_W-1:0]      timer;
  logic                    err, release_err, discard;
  logic [PKT_CNT_W-1:0]    pkt_cnt;
  logic [TMO_CNT_W-1:0]    tmo_cnt;
  logic                    routed;

  assign free_mask = ~i_engine_busy;
  assign grant_inc = (grant == LAST_IDX) ? '0 : grant + ENGINE_IDX_W'(1);

  nts_rr_picker #(
    .NUM_ENGINES  (NUM_ENGINES),
    .ENGINE_IDX_W (ENGINE_IDX_W)
  ) u_picker (
    .free  (free_mask),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Zero-latency broadcast; only the granted engine is told a packet exists.
  assign o_engine_data_valid            = i_dispatch_data_valid;
  assign o_engine_fifo_rd_data          = i_dispatch_fifo_rd_data;
  assign o_grant_idx                    = grant;
  assign o_packets_dispatched           = pkt_cnt;
  assign o_timeouts                     = tmo_cnt;
  assign o_dispatch_packet_read_discard = discard;

  always_comb begin
    state_next                = state;
    release_err               = 1'b0;
    routed                    = (state == ST_GRANT) || (state == ST_ACTIVE);
    o_dispatch_fifo_rd_en     = 1'b0;
    o_engine_packet_available = '0;
    o_engine_fifo_empty       = '1;

    if (routed) begin
      o_dispatch_fifo_rd_en            = i_engine_fifo_rd_en[grant];
      o_engine_packet_available[grant] = i_dispatch_packet_available;
      o_engine_fifo_empty[grant]       = i_dispatch_fifo_empty;
    end

    case (state)
      ST_IDLE: begin
        if (i_dispatch_packet_available && !i_dispatch_fifo_empty && pick_found) begin
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Busy takes priority over an expiring watchdog.
        if (i_engine_busy[grant]) begin
          state_next = ST_ACTIVE;
        end else if (timer == TIMEOUT_V) begin
          state_next  = ST_RELEASE;
          release_err = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // A drained FIFO counts as a normal finish even if busy drops in the same cycle.
        if (i_dispatch_fifo_empty) begin
          state_next = ST_RELEASE;
        end else if (!i_engine_busy[grant]) begin
          state_next  = ST_RELEASE;
          release_err = 1'b1;
        end
      end
      ST_RELEASE: state_next = ST_HOLDOFF;
      ST_HOLDOFF: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state   <= ST_IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      timer   <= '0;
      err     <= 1'b0;
      discard <= 1'b0;
      pkt_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_next;
      discard <= (state_next == ST_RELEASE);

      if (state == ST_IDLE && state_next == ST_GRANT) begin
        grant <= pick_idx;
        timer <= '0;
      end else if (state == ST_GRANT && state_next == ST_GRANT) begin
        timer <= timer + TIMER_W'(1);
      end

      if (state != ST_RELEASE && state_next == ST_RELEASE) begin
        err <= release_err;
      end

      if (state == ST_RELEASE) begin
        rr_ptr <= grant_inc;
        if (err) begin
          tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
        end else begin
          pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/nts_engine_scheduler.md
Name: nts_engine_scheduler

Overview:
Shares one dispatcher receive FIFO between NUM_ENGINES nts_engine instances.
- Picks a free engine round-robin and presents the pending packet to that engine only.
- Routes the granted engine's FIFO read strobe back to the dispatcher.
- Releases the packet with a discard pulse once the FIFO is drained, or when the granted engine fails to start or aborts.
- Sits between the dispatcher FIFO and the engine array; exposes packet and timeout counters.

Parameters:
NUM_ENGINES, 4, number of engines served (2..16)
ENGINE_IDX_W, 2, width of the engine index (clog2 of NUM_ENGINES)
TIMEOUT, 255, cycles allowed between grant and the granted engine raising busy (1..65535)

Ports:
i_clk  in  1  clock
i_areset_n  in  1  asynchronous reset, active low
i_dispatch_packet_available  in  1  dispatcher holds a complete packet
i_dispatch_fifo_empty  in  1  dispatcher FIFO empty
i_dispatch_data_valid  in  8  last-word byte-valid mask
i_dispatch_fifo_rd_data  in  64  FIFO read data
o_dispatch_fifo_rd_en  out  1  FIFO read strobe (from granted engine)
o_dispatch_packet_read_discard  out  1  one-cycle pulse that releases the current packet
i_engine_busy  in  NUM_ENGINES  per-engine busy
i_engine_fifo_rd_en  in  NUM_ENGINES  per-engine read strobe
o_engine_packet_available  out  NUM_ENGINES  one-hot packet-available to granted engine
o_engine_fifo_empty  out  NUM_ENGINES  per-engine view of FIFO empty
o_engine_data_valid  out  8  broadcast of i_dispatch_data_valid
o_engine_fifo_rd_data  out  64  broadcast of i_dispatch_fifo_rd_data
o_grant_idx  out  ENGINE_IDX_W  currently/last granted engine
o_packets_dispatched  out  32  completed packets, wraps
o_timeouts  out  16  timeout or abort releases, wraps

Behaviour:
- Reset (i_areset_n=0, asynchronous):
  - State IDLE; rr pointer 0; o_grant_idx 0; counters 0; timeout counter 0.
  - o_dispatch_fifo_rd_en 0, o_dispatch_packet_read_discard 0.
  - o_engine_packet_available all 0; o_engine_fifo_empty all 1.
- Reset mid-packet: immediately returns to the reset values above. No discard is issued; the dispatcher retains the packet.
- Broadcast paths are combinational, zero latency: o_engine_data_valid and o_engine_fifo_rd_data.
- Combinational routing, valid only in GRANT and ACTIVE:
  - o_dispatch_fifo_rd_en = i_engine_fifo_rd_en[g].
  - o_engine_fifo_empty[g] = i_dispatch_fifo_empty.
  - o_engine_packet_available[g] = i_dispatch_packet_available.
  - Non-granted engines see packet_available 0 and fifo_empty 1; their rd_en is ignored.
  - In all other states rd_en is 0 and every engine sees empty = 1.
- IDLE:
  - Condition: i_dispatch_packet_available=1, i_dispatch_fifo_empty=0, and at least one i_engine_busy bit is 0.
  - Action: pick the first non-busy engine scanning from rr pointer upward, with wrap at NUM_ENGINES-1 to 0.
  - Register it as g (o_grant_idx), clear the timeout counter, go to GRANT.
  - Grant is visible on the engine outputs 1 cycle after the condition is met.
  - All engines busy: remain in IDLE with no output change.
- GRANT:
  - i_engine_busy[g]=1: go to ACTIVE.
  - Otherwise the timeout counter increments each cycle. When it reaches TIMEOUT, go to RELEASE with an error flag.
  - Busy and timeout in the same cycle: busy wins.
- ACTIVE:
  - i_dispatch_fifo_empty=1 (packet drained): go to RELEASE, normal.
  - i_engine_busy[g]=0 while the FIFO is not empty (engine aborted): go to RELEASE with the error flag.
  - Empty and busy drop in the same cycle: treated as normal.
- RELEASE, exactly 1 cycle:
  - o_dispatch_packet_read_discard=1 (registered pulse).
  - Rr pointer becomes g+1 modulo NUM_ENGINES.
  - Increment o_packets_dispatched if normal, else o_timeouts. Both counters wrap without saturation.
  - Go to HOLDOFF.
- HOLDOFF, exactly 1 cycle: gives the dispatcher time to update packet_available; then go to IDLE.
- Throughput and fairness:
  - Minimum packet-to-packet gap is 3 cycles of overhead (IDLE decision, RELEASE, HOLDOFF).
  - Any engine that stays free is granted at least once every NUM_ENGINES packets.
- State encoding: 3-bit; IDLE=0, GRANT=1, ACTIVE=2, RELEASE=3, HOLDOFF=4. Unused codes return to IDLE.

Decomposition:
- Shared include nts_engine_scheduler_defs: state encodings and counter widths.
- Sub-module nts_rr_picker: combinational round-robin first-free search.
  - Inputs: free mask, rr pointer.
  - Outputs: found flag, index.
  - Tested standalone.

Test Plan:
- 4 engines idle, one packet of 5 words; engine 0 reads 5 times then the FIFO goes empty -> grant 0 one cycle after available, 5 rd_en pass-through pulses, one discard pulse, o_packets_dispatched=1, next grant to engine 1.
- Engines 1 and 2 busy, rr pointer 1 -> grant engine 3; with all 4 busy -> stays IDLE, no outputs, until engine 2 frees, then grant 2.
- TIMEOUT=8, granted engine never raises busy -> discard pulse 9 cycles after the grant becomes visible, o_timeouts=1, rr advances.
- Granted engine drops busy after 2 of 6 words -> discard, o_timeouts=1; a non-granted engine asserting rd_en never reaches o_dispatch_fifo_rd_en.
- i_areset_n low in ACTIVE -> all outputs at reset values the same cycle, no discard; after release, the same packet is granted to engine 0.
- 12 back-to-back packets, all engines free -> grants 0,1,2,3,0,… and 3-cycle overhead gaps; o_packets_dispatched=12.
